// File: rtl/vid_mem_server.sv
// Tile/palette RAM server: 1-cycle video reads, CPU writes queued in a FIFO and
// committed only when the target RAM is idle. Optional macro VMEM_VBLANK_ONLY_EN
// further restricts commits to vertical blanking.
module vid_mem_server #(
  parameter int TILE_AW    = 12,
  parameter int PAL_AW     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [15:0]                   tile_RAM_addr,
  input  logic                          tile_rd,
  output logic [7:0]                    tile_ROM_addr,
  input  logic [15:0]                   palette_RAM_addr,
  input  logic                          pal_rd,
  output logic [5:0]                    palette_ROM_addr,
  input  logic                          vblank,
  input  logic                          cpu_wr_valid,
  output logic                          cpu_wr_ready,
  input  logic                          cpu_wr_sel,
  input  logic [15:0]                   cpu_wr_addr,
  input  logic [7:0]                    cpu_wr_data,
  output logic                          init_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [15:0]                   stall_cnt
);

  localparam int MAW = (TILE_AW > PAL_AW) ? TILE_AW : PAL_AW;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  typedef struct packed {
    logic           sel;
    logic [MAW-1:0] addr;
    logic [7:0]     data;
  } wr_req_t;

  state_t         state_q, state_d;
  logic [MAW-1:0] cnt_q;
  logic           run, clr_tile, clr_pal;

  logic [7:0] tile_mem [2**TILE_AW];
  logic [5:0] pal_mem  [2**PAL_AW];

  wr_req_t        fifo_q [FIFO_DEPTH];
  wr_req_t        head;
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q;
  logic           push, pop, blank_ok;

  always_comb begin
    state_d = state_q;
    run     = 1'b0;
    case (state_q)
      S_CLEAR: if (&cnt_q) state_d = S_RUN;
      S_RUN:   run = 1'b1;
      default: state_d = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_CLEAR) cnt_q <= cnt_q + 1'b1;
    end
  end

  // The sweep spans the larger RAM; the smaller one stops once past its depth.
  assign clr_tile = (state_q == S_CLEAR) && (32'(cnt_q) < (32'd1 << TILE_AW));
  assign clr_pal  = (state_q == S_CLEAR) && (32'(cnt_q) < (32'd1 << PAL_AW));

`ifdef VMEM_VBLANK_ONLY_EN
  assign blank_ok = vblank;
`else
  assign blank_ok = 1'b1;
`endif

  assign head         = fifo_q[rd_ptr_q];
  assign cpu_wr_ready = run && (count_q < DEPTH_C);
  assign push         = cpu_wr_valid && cpu_wr_ready;
  assign pop          = run && (count_q != '0) && blank_ok &&
                        (head.sel ? !pal_rd : !tile_rd);

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= '{sel: cpu_wr_sel, addr: cpu_wr_addr[MAW-1:0], data: cpu_wr_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      stall_cnt <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (run && (count_q != '0) && !pop && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

  // Reset blocks commits so queued writes are discarded, not applied.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_tile) tile_mem[cnt_q[TILE_AW-1:0]] <= '0;
      if (clr_pal)  pal_mem[cnt_q[PAL_AW-1:0]]   <= '0;
      if (pop) begin
        if (head.sel) pal_mem[head.addr[PAL_AW-1:0]]   <= head.data[5:0];
        else          tile_mem[head.addr[TILE_AW-1:0]] <= head.data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tile_ROM_addr    <= '0;
      palette_ROM_addr <= '0;
    end else begin
      if (run && tile_rd) tile_ROM_addr    <= tile_mem[tile_RAM_addr[TILE_AW-1:0]];
      if (run && pal_rd)  palette_ROM_addr <= pal_mem[palette_RAM_addr[PAL_AW-1:0]];
    end
  end

  assign init_done  = (state_q == S_RUN);
  assign fifo_count = count_q;

  logic unused_bits;
  assign unused_bits = ^{vblank, tile_RAM_addr[15:TILE_AW], palette_RAM_addr[15:PAL_AW],
                         cpu_wr_addr[15:MAW], head};

endmodule

// File: tb/tb_vid_mem_server.sv
// Directed bench for vid_mem_server (TILE_AW=4, PAL_AW=3, FIFO_DEPTH=4, default build).
module tb_vid_mem_server;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] tile_RAM_addr, palette_RAM_addr, cpu_wr_addr;
  logic        tile_rd, pal_rd, vblank, cpu_wr_valid, cpu_wr_sel;
  logic [7:0]  cpu_wr_data, tile_ROM_addr;
  logic [5:0]  palette_ROM_addr;
  logic        cpu_wr_ready, init_done;
  logic [2:0]  fifo_count;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  vid_mem_server #(.TILE_AW(4), .PAL_AW(3), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .tile_RAM_addr(tile_RAM_addr), .tile_rd(tile_rd), .tile_ROM_addr(tile_ROM_addr),
    .palette_RAM_addr(palette_RAM_addr), .pal_rd(pal_rd), .palette_ROM_addr(palette_ROM_addr),
    .vblank(vblank), .cpu_wr_valid(cpu_wr_valid), .cpu_wr_ready(cpu_wr_ready),
    .cpu_wr_sel(cpu_wr_sel), .cpu_wr_addr(cpu_wr_addr), .cpu_wr_data(cpu_wr_data),
    .init_done(init_done), .fifo_count(fifo_count), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        trd;
    logic [15:0] ta;
    logic        prd;
    logic [15:0] pa;
    logic        wv;
    logic        ws;
    logic [15:0] wa;
    logic [7:0]  wd;
    logic [7:0]  e_t;
    logic [5:0]  e_p;
    logic [2:0]  e_cnt;
    logic        e_rdy;
    logic [15:0] e_stall;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    tile_rd = 0; tile_RAM_addr = 0; pal_rd = 0; palette_RAM_addr = 0;
    cpu_wr_valid = 0; cpu_wr_sel = 0; cpu_wr_addr = 0; cpu_wr_data = 0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_init_done"}, 32'(init_done), 0);
    chk({tag, "_ready"},     32'(cpu_wr_ready), 0);
    chk({tag, "_count"},     32'(fifo_count), 0);
    chk({tag, "_stall"},     32'(stall_cnt), 0);
    chk({tag, "_tile_q"},    32'(tile_ROM_addr), 0);
    chk({tag, "_pal_q"},     32'(palette_ROM_addr), 0);
  endtask

  // Sweep takes 16 edges; writes offered during it must be refused.
  task automatic clear_phase(input string tag);
    rst = 0;
    cpu_wr_valid = 1; cpu_wr_addr = 16'h3; cpu_wr_data = 8'hEE;
    tile_rd = 1; pal_rd = 1;
    for (int i = 1; i <= 16; i++) begin
      chk($sformatf("%s_ready_c%0d", tag, i), 32'(cpu_wr_ready), 0);
      step();
      chk($sformatf("%s_init_c%0d", tag, i), 32'(init_done), (i == 16) ? 1 : 0);
    end
    chk({tag, "_count_after_clear"}, 32'(fifo_count), 0);
    chk({tag, "_tile_q_after_clear"}, 32'(tile_ROM_addr), 0);
    idle();
  endtask

  task automatic read_all_zero(input string tag);
    for (int a = 0; a < 16; a++) begin
      tile_rd = 1; tile_RAM_addr = 16'(a);
      pal_rd = 1; palette_RAM_addr = 16'(a & 7);
      step();
      chk($sformatf("%s_tile%0d", tag, a), 32'(tile_ROM_addr), 0);
      chk($sformatf("%s_pal%0d", tag, a & 7), 32'(palette_ROM_addr), 0);
    end
    idle();
  endtask

  initial begin
    vblank = 0;
    idle();
    rst = 1;
    step();
    check_reset_state("rst1");
    clear_phase("clr1");
    read_all_zero("rd1");

    //          trd ta       prd pa       wv ws wa       wd      e_t    e_p    cnt rdy stall
    vq.push_back('{0, 16'h0,    0, 16'h0,    1, 0, 16'h5,   8'hA7, 8'h00, 6'h00, 1, 1, 0});
    vq.push_back('{0, 16'h0,    0, 16'h0,    0, 0, 16'h0,   8'h00, 8'h00, 6'h00, 0, 1, 0});
    vq.push_back('{1, 16'hFFF5, 0, 16'h0,    0, 0, 16'h0,   8'h00, 8'hA7, 6'h00, 0, 1, 0});
    vq.push_back('{0, 16'h0,    0, 16'h0,    0, 0, 16'h0,   8'h00, 8'hA7, 6'h00, 0, 1, 0});
    vq.push_back('{1, 16'h5,    0, 16'h0,    1, 0, 16'h1,   8'h11, 8'hA7, 6'h00, 1, 1, 0});
    vq.push_back('{1, 16'h5,    0, 16'h0,    1, 0, 16'h2,   8'h22, 8'hA7, 6'h00, 2, 1, 1});
    vq.push_back('{1, 16'h5,    0, 16'h0,    1, 0, 16'h3,   8'h33, 8'hA7, 6'h00, 3, 1, 2});
    vq.push_back('{1, 16'h5,    0, 16'h0,    1, 0, 16'h4,   8'h44, 8'hA7, 6'h00, 4, 0, 3});
    vq.push_back('{1, 16'h5,    0, 16'h0,    1, 0, 16'h6,   8'h66, 8'hA7, 6'h00, 4, 0, 4});
    vq.push_back('{0, 16'h0,    0, 16'h0,    1, 0, 16'h6,   8'h66, 8'hA7, 6'h00, 3, 1, 4});
    vq.push_back('{0, 16'h0,    0, 16'h0,    1, 0, 16'h6,   8'h66, 8'hA7, 6'h00, 3, 1, 4});
    vq.push_back('{0, 16'h0,    0, 16'h0,    0, 0, 16'h0,   8'h00, 8'hA7, 6'h00, 2, 1, 4});
    vq.push_back('{0, 16'h0,    0, 16'h0,    0, 0, 16'h0,   8'h00, 8'hA7, 6'h00, 1, 1, 4});
    vq.push_back('{0, 16'h0,    0, 16'h0,    0, 0, 16'h0,   8'h00, 8'hA7, 6'h00, 0, 1, 4});
    vq.push_back('{1, 16'h1,    0, 16'h0,    0, 0, 16'h0,   8'h00, 8'h11, 6'h00, 0, 1, 4});
    vq.push_back('{1, 16'h2,    0, 16'h0,    0, 0, 16'h0,   8'h00, 8'h22, 6'h00, 0, 1, 4});
    vq.push_back('{1, 16'h4,    0, 16'h0,    0, 0, 16'h0,   8'h00, 8'h44, 6'h00, 0, 1, 4});
    vq.push_back('{1, 16'h6,    0, 16'h0,    0, 0, 16'h0,   8'h00, 8'h66, 6'h00, 0, 1, 4});
    vq.push_back('{1, 16'h3,    0, 16'h0,    0, 0, 16'h0,   8'h00, 8'h33, 6'h00, 0, 1, 4});
    vq.push_back('{0, 16'h0,    1, 16'h0,    1, 0, 16'h2,   8'h3C, 8'h33, 6'h00, 1, 1, 4});
    vq.push_back('{0, 16'h0,    1, 16'h0,    1, 1, 16'h1,   8'h2A, 8'h33, 6'h00, 1, 1, 4});
    vq.push_back('{0, 16'h0,    1, 16'h1,    0, 0, 16'h0,   8'h00, 8'h33, 6'h00, 1, 1, 5});
    vq.push_back('{0, 16'h0,    1, 16'h1,    0, 0, 16'h0,   8'h00, 8'h33, 6'h00, 1, 1, 6});
    vq.push_back('{1, 16'h2,    0, 16'h0,    0, 0, 16'h0,   8'h00, 8'h3C, 6'h00, 0, 1, 6});
    vq.push_back('{0, 16'h0,    1, 16'hFFF9, 0, 0, 16'h0,   8'h00, 8'h3C, 6'h2A, 0, 1, 6});
    vq.push_back('{0, 16'h0,    0, 16'h0,    1, 0, 16'h0017, 8'h5A, 8'h3C, 6'h2A, 1, 1, 6});
    vq.push_back('{0, 16'h0,    0, 16'h0,    0, 0, 16'h0,   8'h00, 8'h3C, 6'h2A, 0, 1, 6});
    vq.push_back('{1, 16'h7,    0, 16'h0,    0, 0, 16'h0,   8'h00, 8'h5A, 6'h2A, 0, 1, 6});

    foreach (vq[i]) begin
      tile_rd = vq[i].trd; tile_RAM_addr = vq[i].ta;
      pal_rd = vq[i].prd;  palette_RAM_addr = vq[i].pa;
      cpu_wr_valid = vq[i].wv; cpu_wr_sel = vq[i].ws;
      cpu_wr_addr = vq[i].wa;  cpu_wr_data = vq[i].wd;
      step();
      chk($sformatf("v%0d_tile_q", i), 32'(tile_ROM_addr), 32'(vq[i].e_t));
      chk($sformatf("v%0d_pal_q", i),  32'(palette_ROM_addr), 32'(vq[i].e_p));
      chk($sformatf("v%0d_count", i),  32'(fifo_count), 32'(vq[i].e_cnt));
      chk($sformatf("v%0d_ready", i),  32'(cpu_wr_ready), 32'(vq[i].e_rdy));
      chk($sformatf("v%0d_stall", i),  32'(stall_cnt), 32'(vq[i].e_stall));
    end
    idle();

    // Three tile writes held back by continuous reads, then reset instead of commit.
    tile_rd = 1; tile_RAM_addr = 0;
    for (int i = 0; i < 3; i++) begin
      cpu_wr_valid = 1; cpu_wr_sel = 0;
      cpu_wr_addr = 16'(8 + i); cpu_wr_data = 8'hF0 + 8'(i);
      step();
      chk($sformatf("pend_count%0d", i), 32'(fifo_count), 32'(i + 1));
    end
    idle();
    rst = 1;
    step();
    check_reset_state("rst2");
    clear_phase("clr2");
    read_all_zero("rd2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
